// File: rtl/spu_pcx_req_ctl_pkg.sv
// Shared definitions for the SPU PCX request controller: FSM encoding and defaults.
package spu_pcx_req_ctl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_REQ   = 2'b01,
    ST_DRAIN = 2'b10
  } pcx_state_e;

  localparam int LD_MAX_DEFAULT = 4;
  localparam int CNT_W_DEFAULT  = 3;

endpackage

// File: rtl/spu_pcx_rr_arb.sv
// Two-requester round-robin arbiter (load vs store); last_st remembers the previous winner.
module spu_pcx_rr_arb
  import spu_pcx_req_ctl_pkg::*;
(
  input  logic clk,
  input  logic reset_l,
  input  logic en,
  input  logic req_ld,
  input  logic req_st,
  output logic gnt_ld,
  output logic gnt_st
);

  logic last_st_r;

  // On contention the requester that did not win last time gets the slot.
  assign gnt_ld = en & req_ld & (~req_st | last_st_r);
  assign gnt_st = en & req_st & (~req_ld | ~last_st_r);

  // Winner history, updated on every capture; starts as store so a load wins first.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      last_st_r <= 1'b1;
    end else if (gnt_ld | gnt_st) begin
      last_st_r <= gnt_st;
    end else begin
      last_st_r <= last_st_r;
    end
  end

endmodule

// File: rtl/spu_pcx_req_ctl.sv
// SPU-to-LSU PCX request controller: arbitrates MA load/store, sequences packet capture,
// holds the packet until granted, and tracks outstanding loads/stores with abort-drain.
module spu_pcx_req_ctl
  import spu_pcx_req_ctl_pkg::*;
#(
  parameter int LD_MAX = LD_MAX_DEFAULT,
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic             rclk,
  input  logic             reset_l,
  input  logic             spu_mald_req,
  input  logic             spu_mast_req,
  input  logic             lsu_spu_pcx_grant,
  input  logic             lsu_spu_ldret,
  input  logic             lsu_spu_stack,
  input  logic             spu_ctl_abort,
  output logic             spu_wen_pcx_wen,
  output logic             spu_wen_pcx_7170_sel,
  output logic             spu_pcx_sel_st,
  output logic             spu_lsu_ldst_req,
  output logic             spu_mald_gnt,
  output logic             spu_mast_gnt,
  output logic [CNT_W-1:0] spu_pcx_ld_outst,
  output logic             spu_pcx_idle
);

  localparam logic [CNT_W-1:0] LD_MAX_C = CNT_W'(LD_MAX);

  pcx_state_e       state_r;
  logic [CNT_W-1:0] outst_r;
  logic             st_pend_r;
  logic             abort_pend_r;
  logic             sel_st_r;

  logic             elig_ld_s;
  logic             elig_st_s;
  logic             cap_en_s;
  logic             gnt_ld_s;
  logic             gnt_st_s;
  logic             capture_s;
  logic             ld_granted_s;
  logic             st_granted_s;
  logic [CNT_W-1:0] outst_nxt_s;
  logic             st_pend_nxt_s;
  logic             drained_nxt_s;

  assign elig_ld_s = spu_mald_req & (outst_r < LD_MAX_C);
  assign elig_st_s = spu_mast_req & ~st_pend_r;
  assign cap_en_s  = reset_l & (state_r == ST_IDLE) & ~abort_pend_r;

  spu_pcx_rr_arb u_arb (
    .clk     (rclk),
    .reset_l (reset_l),
    .en      (cap_en_s),
    .req_ld  (elig_ld_s),
    .req_st  (elig_st_s),
    .gnt_ld  (gnt_ld_s),
    .gnt_st  (gnt_st_s)
  );

  assign capture_s    = gnt_ld_s | gnt_st_s;
  assign ld_granted_s = (state_r == ST_REQ) & lsu_spu_pcx_grant & ~sel_st_r;
  assign st_granted_s = (state_r == ST_REQ) & lsu_spu_pcx_grant & sel_st_r;

  // Capture is same-cycle so the packet mux must follow the winner before sel_st_r updates.
  assign spu_wen_pcx_wen      = capture_s;
  assign spu_wen_pcx_7170_sel = capture_s;
  assign spu_mald_gnt         = gnt_ld_s;
  assign spu_mast_gnt         = gnt_st_s;
  assign spu_pcx_sel_st       = capture_s ? gnt_st_s : sel_st_r;
  assign spu_lsu_ldst_req     = (state_r == ST_REQ);
  assign spu_pcx_ld_outst     = outst_r;
  assign spu_pcx_idle         = (state_r == ST_IDLE) & (outst_r == {CNT_W{1'b0}})
                                & ~st_pend_r & ~abort_pend_r;

  // Next values of the outstanding trackers; a return at zero is dropped.
  always_comb begin
    outst_nxt_s   = outst_r;
    st_pend_nxt_s = st_pend_r;
    if (ld_granted_s && lsu_spu_ldret) begin
      outst_nxt_s = outst_r;
    end else if (ld_granted_s) begin
      outst_nxt_s = outst_r + CNT_W'(1);
    end else if (lsu_spu_ldret && (outst_r != {CNT_W{1'b0}})) begin
      outst_nxt_s = outst_r - CNT_W'(1);
    end else begin
      outst_nxt_s = outst_r;
    end
    if (st_granted_s) begin
      st_pend_nxt_s = 1'b1;
    end else if (lsu_spu_stack) begin
      st_pend_nxt_s = 1'b0;
    end else begin
      st_pend_nxt_s = st_pend_r;
    end
  end

  // Drain completes as the last return lands, so idle shows on the following cycle.
  assign drained_nxt_s = (outst_nxt_s == {CNT_W{1'b0}}) & ~st_pend_nxt_s;

  // Request sequencing FSM with outstanding-load/store and abort tracking.
  always_ff @(posedge rclk) begin
    if (!reset_l) begin
      state_r      <= ST_IDLE;
      outst_r      <= {CNT_W{1'b0}};
      st_pend_r    <= 1'b0;
      abort_pend_r <= 1'b0;
      sel_st_r     <= 1'b0;
    end else begin
      outst_r   <= outst_nxt_s;
      st_pend_r <= st_pend_nxt_s;
      if (capture_s) begin
        sel_st_r <= gnt_st_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            state_r <= ST_REQ;
            if (spu_ctl_abort) begin
              abort_pend_r <= 1'b1;
            end
          end else if (spu_ctl_abort && ((outst_r != {CNT_W{1'b0}}) || st_pend_r)) begin
            state_r      <= ST_DRAIN;
            abort_pend_r <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (spu_ctl_abort) begin
            abort_pend_r <= 1'b1;
          end
          if (lsu_spu_pcx_grant) begin
            state_r <= (abort_pend_r || spu_ctl_abort) ? ST_DRAIN : ST_IDLE;
          end else begin
            state_r <= ST_REQ;
          end
        end
        ST_DRAIN: begin
          if (drained_nxt_s) begin
            abort_pend_r <= 1'b0;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          abort_pend_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spu_pcx_req_ctl.sv
// Directed testbench for spu_pcx_req_ctl; inputs change 1ns after rclk rises, outputs sampled 1ns later.
module tb_spu_pcx_req_ctl;

  logic       rclk;
  logic       reset_l;
  logic       spu_mald_req;
  logic       spu_mast_req;
  logic       lsu_spu_pcx_grant;
  logic       lsu_spu_ldret;
  logic       lsu_spu_stack;
  logic       spu_ctl_abort;
  logic       spu_wen_pcx_wen;
  logic       spu_wen_pcx_7170_sel;
  logic       spu_pcx_sel_st;
  logic       spu_lsu_ldst_req;
  logic       spu_mald_gnt;
  logic       spu_mast_gnt;
  logic [2:0] spu_pcx_ld_outst;
  logic       spu_pcx_idle;

  int checks = 0;
  int passes = 0;

  spu_pcx_req_ctl #(.LD_MAX(4), .CNT_W(3)) dut (
    .rclk                 (rclk),
    .reset_l              (reset_l),
    .spu_mald_req         (spu_mald_req),
    .spu_mast_req         (spu_mast_req),
    .lsu_spu_pcx_grant    (lsu_spu_pcx_grant),
    .lsu_spu_ldret        (lsu_spu_ldret),
    .lsu_spu_stack        (lsu_spu_stack),
    .spu_ctl_abort        (spu_ctl_abort),
    .spu_wen_pcx_wen      (spu_wen_pcx_wen),
    .spu_wen_pcx_7170_sel (spu_wen_pcx_7170_sel),
    .spu_pcx_sel_st       (spu_pcx_sel_st),
    .spu_lsu_ldst_req     (spu_lsu_ldst_req),
    .spu_mald_gnt         (spu_mald_gnt),
    .spu_mast_gnt         (spu_mast_gnt),
    .spu_pcx_ld_outst     (spu_pcx_ld_outst),
    .spu_pcx_idle         (spu_pcx_idle)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    spu_mald_req = 1'b0;
    spu_mast_req = 1'b0;
    lsu_spu_pcx_grant = 1'b0;
    lsu_spu_ldret = 1'b0;
    lsu_spu_stack = 1'b0;
    spu_ctl_abort = 1'b0;
    tick();
    tick();
    reset_l = 1'b1;
  endtask

  // One load captured then granted after one REQ cycle; ends in IDLE.
  task automatic load_txn();
    spu_mald_req = 1'b1;
    #1;
    tick();
    spu_mald_req = 1'b0;
    lsu_spu_pcx_grant = 1'b1;
    tick();
    lsu_spu_pcx_grant = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_pcx_sel_st, spu_lsu_ldst_req, spu_mald_gnt, spu_mast_gnt} !== 6'b000000)
      $display("FAIL reset_outs got %b exp 000000", {spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_pcx_sel_st, spu_lsu_ldst_req, spu_mald_gnt, spu_mast_gnt});
    else passes++;
    checks++;
    if (spu_pcx_ld_outst !== 3'd0 || spu_pcx_idle !== 1'b1)
      $display("FAIL reset_state got outst=%0d idle=%b exp outst=0 idle=1", spu_pcx_ld_outst, spu_pcx_idle);
    else passes++;
  endtask

  task automatic test_load_hold();
    do_reset();
    spu_mald_req = 1'b1;
    #1;
    checks++;
    if ({spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_mald_gnt, spu_mast_gnt, spu_pcx_sel_st} !== 5'b11100)
      $display("FAIL ld_capture got %b exp 11100", {spu_wen_pcx_wen, spu_wen_pcx_7170_sel, spu_mald_gnt, spu_mast_gnt, spu_pcx_sel_st});
    else passes++;
    tick();
    spu_mald_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (spu_lsu_ldst_req !== 1'b1 || spu_wen_pcx_wen !== 1'b0 || spu_pcx_sel_st !== 1'b0)
        $display("FAIL ld_hold cyc%0d got req=%b wen=%b sel=%b exp 1 0 0", i, spu_lsu_ldst_req, spu_wen_pcx_wen, spu_pcx_sel_st);
      else passes++;
      tick();
    end
    lsu_spu_pcx_grant = 1'b1;
    tick();
    lsu_spu_pcx_grant = 1'b0;
    #1;
    checks++;
    if (spu_lsu_ldst_req !== 1'b0 || spu_pcx_ld_outst !== 3'd1 || spu_pcx_idle !== 1'b0)
      $display("FAIL ld_granted got req=%b outst=%0d idle=%b exp 0 1 0", spu_lsu_ldst_req, spu_pcx_ld_outst, spu_pcx_idle);
    else passes++;
  endtask

  task automatic test_arbitration();
    logic [4:0] exp_st;
    exp_st = 5'b10010;
    do_reset();
    spu_mald_req = 1'b1;
    spu_mast_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (k == 4) begin
        checks++;
        if (spu_pcx_ld_outst !== 3'd3)
          $display("FAIL arb_outst got %0d exp 3", spu_pcx_ld_outst);
        else passes++;
      end
      checks++;
      if (spu_wen_pcx_wen !== 1'b1 || spu_mald_gnt !== ~exp_st[k] || spu_mast_gnt !== exp_st[k] || spu_pcx_sel_st !== exp_st[k])
        $display("FAIL arb_seq%0d got wen=%b ld=%b st=%b sel=%b exp st=%b", k, spu_wen_pcx_wen, spu_mald_gnt, spu_mast_gnt, spu_pcx_sel_st, exp_st[k]);
      else passes++;
      tick();
      lsu_spu_pcx_grant = 1'b1;
      lsu_spu_stack = (k == 3);
      tick();
      lsu_spu_pcx_grant = 1'b0;
      lsu_spu_stack = 1'b0;
    end
    spu_mald_req = 1'b0;
    spu_mast_req = 1'b0;
  endtask

  task automatic test_ld_max();
    do_reset();
    spu_mald_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (spu_mald_gnt !== 1'b1)
        $display("FAIL ldmax_cap%0d got gnt=%b exp 1", k, spu_mald_gnt);
      else passes++;
      tick();
      lsu_spu_pcx_grant = 1'b1;
      tick();
      lsu_spu_pcx_grant = 1'b0;
    end
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd4 || spu_wen_pcx_wen !== 1'b0)
      $display("FAIL ldmax_full got outst=%0d wen=%b exp 4 0", spu_pcx_ld_outst, spu_wen_pcx_wen);
    else passes++;
    tick();
    lsu_spu_ldret = 1'b1;
    #1;
    checks++;
    if (spu_wen_pcx_wen !== 1'b0 || spu_mald_gnt !== 1'b0)
      $display("FAIL ldmax_block got wen=%b gnt=%b exp 0 0", spu_wen_pcx_wen, spu_mald_gnt);
    else passes++;
    tick();
    lsu_spu_ldret = 1'b0;
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd3 || spu_mald_gnt !== 1'b1 || spu_wen_pcx_wen !== 1'b1)
      $display("FAIL ldmax_resume got outst=%0d gnt=%b wen=%b exp 3 1 1", spu_pcx_ld_outst, spu_mald_gnt, spu_wen_pcx_wen);
    else passes++;
    spu_mald_req = 1'b0;
  endtask

  task automatic test_counter_edges();
    do_reset();
    load_txn();
    load_txn();
    spu_mald_req = 1'b1;
    #1;
    tick();
    spu_mald_req = 1'b0;
    lsu_spu_pcx_grant = 1'b1;
    lsu_spu_ldret = 1'b1;
    tick();
    lsu_spu_pcx_grant = 1'b0;
    lsu_spu_ldret = 1'b0;
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd2 || spu_lsu_ldst_req !== 1'b0)
      $display("FAIL cnt_grant_ret got outst=%0d req=%b exp 2 0", spu_pcx_ld_outst, spu_lsu_ldst_req);
    else passes++;
    lsu_spu_ldret = 1'b1;
    tick();
    tick();
    lsu_spu_ldret = 1'b0;
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd0)
      $display("FAIL cnt_ret_to0 got %0d exp 0", spu_pcx_ld_outst);
    else passes++;
    lsu_spu_ldret = 1'b1;
    tick();
    lsu_spu_ldret = 1'b0;
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd0 || spu_pcx_idle !== 1'b1)
      $display("FAIL cnt_underflow got outst=%0d idle=%b exp 0 1", spu_pcx_ld_outst, spu_pcx_idle);
    else passes++;
  endtask

  task automatic test_abort_drain();
    do_reset();
    load_txn();
    spu_mald_req = 1'b1;
    #1;
    tick();
    spu_ctl_abort = 1'b1;
    tick();
    spu_ctl_abort = 1'b0;
    #1;
    checks++;
    if (spu_lsu_ldst_req !== 1'b1 || spu_wen_pcx_wen !== 1'b0)
      $display("FAIL abort_hold got req=%b wen=%b exp 1 0", spu_lsu_ldst_req, spu_wen_pcx_wen);
    else passes++;
    tick();
    lsu_spu_pcx_grant = 1'b1;
    tick();
    lsu_spu_pcx_grant = 1'b0;
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd2 || spu_lsu_ldst_req !== 1'b0 || spu_wen_pcx_wen !== 1'b0 || spu_pcx_idle !== 1'b0)
      $display("FAIL abort_drain got outst=%0d req=%b wen=%b idle=%b exp 2 0 0 0", spu_pcx_ld_outst, spu_lsu_ldst_req, spu_wen_pcx_wen, spu_pcx_idle);
    else passes++;
    tick();
    #1;
    checks++;
    if (spu_wen_pcx_wen !== 1'b0 || spu_mald_gnt !== 1'b0)
      $display("FAIL abort_nocap got wen=%b gnt=%b exp 0 0", spu_wen_pcx_wen, spu_mald_gnt);
    else passes++;
    spu_mald_req = 1'b0;
    lsu_spu_ldret = 1'b1;
    tick();
    lsu_spu_ldret = 1'b0;
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd1 || spu_pcx_idle !== 1'b0)
      $display("FAIL abort_ret1 got outst=%0d idle=%b exp 1 0", spu_pcx_ld_outst, spu_pcx_idle);
    else passes++;
    lsu_spu_ldret = 1'b1;
    tick();
    lsu_spu_ldret = 1'b0;
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd0 || spu_pcx_idle !== 1'b1)
      $display("FAIL abort_idle got outst=%0d idle=%b exp 0 1", spu_pcx_ld_outst, spu_pcx_idle);
    else passes++;
    spu_mald_req = 1'b1;
    #1;
    checks++;
    if (spu_mald_gnt !== 1'b1)
      $display("FAIL abort_resume got gnt=%b exp 1", spu_mald_gnt);
    else passes++;
    spu_mald_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_req();
    do_reset();
    spu_mald_req = 1'b1;
    spu_mast_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      lsu_spu_pcx_grant = 1'b1;
      tick();
      lsu_spu_pcx_grant = 1'b0;
    end
    tick();
    spu_mald_req = 1'b0;
    spu_mast_req = 1'b0;
    #1;
    checks++;
    if (spu_lsu_ldst_req !== 1'b1 || spu_pcx_ld_outst !== 3'd3)
      $display("FAIL rst_pre got req=%b outst=%0d exp 1 3", spu_lsu_ldst_req, spu_pcx_ld_outst);
    else passes++;
    reset_l = 1'b0;
    tick();
    #1;
    checks++;
    if (spu_pcx_ld_outst !== 3'd0 || spu_lsu_ldst_req !== 1'b0 || spu_pcx_idle !== 1'b1 || spu_wen_pcx_wen !== 1'b0)
      $display("FAIL rst_req got outst=%0d req=%b idle=%b wen=%b exp 0 0 1 0", spu_pcx_ld_outst, spu_lsu_ldst_req, spu_pcx_idle, spu_wen_pcx_wen);
    else passes++;
    reset_l = 1'b1;
    spu_mast_req = 1'b1;
    #1;
    checks++;
    if (spu_mast_gnt !== 1'b1 || spu_pcx_sel_st !== 1'b1)
      $display("FAIL rst_stpend got gnt=%b sel=%b exp 1 1", spu_mast_gnt, spu_pcx_sel_st);
    else passes++;
    spu_mald_req = 1'b1;
    #1;
    checks++;
    if (spu_mald_gnt !== 1'b1 || spu_mast_gnt !== 1'b0)
      $display("FAIL rst_lastst got ld=%b st=%b exp 1 0", spu_mald_gnt, spu_mast_gnt);
    else passes++;
    spu_mald_req = 1'b0;
    spu_mast_req = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_arbitration();
    test_ld_max();
    test_counter_edges();
    test_abort_drain();
    test_reset_in_req();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
